instruction_fetch: RTL and testbench

Fetch-stage front end of the 8-bit pipelined processor. It drives the instruction-memory address, steps the PC, and recognises two-byte instructions. It presents each fetched byte plus a second-byte flag to the instruction register (its `ir_new`, `sf1_in` and `flush` inputs). It also loads the reset and interrupt vectors, follows taken-branch redirects and honours hazard stalls.

---
 rtl/instruction_fetch_pkg.sv | 14 +
 rtl/instruction_fetch.sv | 90 +++++++++
 tb/tb_instruction_fetch.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage constants: state encodings and default vector/opcode values.
// The decode unit imports TWO_BYTE_OPC_DEF from here too.
package instruction_fetch_pkg;

    localparam logic [1:0] VEC    = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] SECOND = 2'd2;
    localparam logic [1:0] INT    = 2'd3;

    localparam logic [7:0] RST_VEC_DEF      = 8'h00;
    localparam logic [7:0] INT_VEC_DEF      = 8'h01;
    localparam logic [3:0] TWO_BYTE_OPC_DEF = 4'hC;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch front end: PC stepping, vector loads, redirects, stalls and
// two-byte instruction tagging for the instruction register.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int              ADDR_W       = 8,
    parameter int              DATA_W       = 8,
    parameter logic [ADDR_W-1:0] RST_VEC    = RST_VEC_DEF,
    parameter logic [ADDR_W-1:0] INT_VEC    = INT_VEC_DEF,
    parameter logic [3:0]      TWO_BYTE_OPC = TWO_BYTE_OPC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              irq,
    input  logic [DATA_W-1:0] imem_data,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] ir_new,
    output logic              sf1_out,
    output logic              ir_flush,
    output logic              int_ack,
    output logic [ADDR_W-1:0] ret_pc
);

    logic [ADDR_W-1:0] pc, pc_n, ret_n;
    logic [1:0]        state, state_n;
    logic              two_byte;

    assign two_byte = imem_data[DATA_W-1 -: 4] == TWO_BYTE_OPC;

    always_comb begin
        imem_addr = pc;
        ir_new    = imem_data;
        sf1_out   = 1'b0;
        ir_flush  = 1'b0;
        int_ack   = 1'b0;
        pc_n      = pc;
        state_n   = state;
        ret_n     = ret_pc;
        unique case (state)
            VEC: begin
                imem_addr = RST_VEC;
                ir_new    = '0;
                pc_n      = ADDR_W'(imem_data);
                state_n   = RUN;
            end
            INT: begin
                imem_addr = INT_VEC;
                ir_new    = '0;
                int_ack   = 1'b1;
                pc_n      = ADDR_W'(imem_data);
                state_n   = RUN;
            end
            default: begin
                sf1_out = state == SECOND;
                if (branch_taken) begin
                    pc_n     = branch_target;
                    state_n  = RUN;
                    ir_flush = 1'b1;
                    ir_new   = '0;
                end else if (stall) begin
                    // hold: the IR reloads the same byte
                    pc_n    = pc;
                end else if (irq && state == RUN) begin
                    ret_n   = pc;
                    ir_new  = '0;
                    state_n = INT;
                end else begin
                    pc_n    = pc + ADDR_W'(1);
                    state_n = (state == RUN && two_byte) ? SECOND : RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc     <= '0;
            state  <= VEC;
            ret_pc <= '0;
        end else begin
            pc     <= pc_n;
            state  <= state_n;
            ret_pc <= ret_n;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: driver queues expected per-cycle
// outputs, monitor pops and compares on every falling edge.
module tb_instruction_fetch;

    typedef struct {
        string      name;
        logic [7:0] addr;
        logic [7:0] ir;
        logic       sf1;
        logic       flush;
        logic       ack;
        logic       chk_ret;
        logic [7:0] ret;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       irq = 1'b0;
    logic [7:0] imem_data;
    logic [7:0] imem_addr;
    logic [7:0] ir_new;
    logic       sf1_out;
    logic       ir_flush;
    logic       int_ack;
    logic [7:0] ret_pc;

    logic [7:0] mem [256];
    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instruction_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .irq          (irq),
        .imem_data    (imem_data),
        .imem_addr    (imem_addr),
        .ir_new       (ir_new),
        .sf1_out      (sf1_out),
        .ir_flush     (ir_flush),
        .int_ack      (int_ack),
        .ret_pc       (ret_pc)
    );

    function automatic void chk(string n, logic [7:0] act, logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, want);
        end
    endfunction

    function automatic exp_t E(string n, logic [7:0] a, logic [7:0] i,
                               logic s, logic f, logic k);
        exp_t e;
        e.name = n; e.addr = a; e.ir = i; e.sf1 = s;
        e.flush = f; e.ack = k; e.chk_ret = 1'b0; e.ret = 8'h00;
        return e;
    endfunction

    function automatic exp_t ER(exp_t e, logic [7:0] r);
        exp_t o = e;
        o.chk_ret = 1'b1;
        o.ret = r;
        return o;
    endfunction

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".addr"}, imem_addr, e.addr);
                chk({e.name, ".ir"}, ir_new, e.ir);
                chk({e.name, ".sf1"}, {7'd0, sf1_out}, {7'd0, e.sf1});
                chk({e.name, ".flush"}, {7'd0, ir_flush}, {7'd0, e.flush});
                chk({e.name, ".ack"}, {7'd0, int_ack}, {7'd0, e.ack});
                if (e.chk_ret)
                    chk({e.name, ".ret"}, ret_pc, e.ret);
            end
        end
    end

    task automatic cyc(input logic r, input logic s, input logic b,
                       input logic [7:0] t, input logic i, input exp_t e);
        rst = r; stall = s; branch_taken = b; branch_target = t; irq = i;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waits;
        foreach (mem[k]) mem[k] = 8'h00;
        mem[8'h00] = 8'h10;
        mem[8'h10] = 8'h35;
        mem[8'h11] = 8'h36;
        @(posedge clk);
        #1;
        // reset vector
        cyc(1, 0, 0, 8'h00, 0, ER(E("rst0", 8'h00, 8'h00, 0, 0, 0), 8'h00));
        cyc(1, 0, 0, 8'h00, 0, E("rst1", 8'h00, 8'h00, 0, 0, 0));
        cyc(0, 1, 1, 8'h55, 1, E("vec", 8'h00, 8'h00, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 0, E("first", 8'h10, 8'h35, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 0, E("second", 8'h11, 8'h36, 0, 0, 0));

        // new program loaded under reset
        rst = 1'b1;
        mem[8'h01] = 8'h80;
        mem[8'h10] = 8'hC4; mem[8'h11] = 8'h7E;
        mem[8'h12] = 8'h20; mem[8'h13] = 8'h21;
        mem[8'h80] = 8'h55; mem[8'h81] = 8'h56;
        mem[8'h40] = 8'hC9; mem[8'h41] = 8'hAA;
        mem[8'hFF] = 8'h33;
        cyc(1, 0, 0, 8'h00, 0, E("b_rst", 8'h00, 8'h00, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 0, E("b_vec", 8'h00, 8'h00, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 0, E("tb_op", 8'h10, 8'hC4, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 0, E("tb_b2", 8'h11, 8'h7E, 1, 0, 0));
        cyc(0, 1, 0, 8'h00, 0, E("stall0", 8'h12, 8'h20, 0, 0, 0));
        cyc(0, 1, 0, 8'h00, 0, E("stall1", 8'h12, 8'h20, 0, 0, 0));
        cyc(0, 1, 0, 8'h00, 0, E("stall2", 8'h12, 8'h20, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 1, E("irq_acc", 8'h12, 8'h00, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 0, ER(E("int", 8'h01, 8'h00, 0, 0, 1), 8'h12));
        cyc(0, 0, 0, 8'h00, 0, E("isr0", 8'h80, 8'h55, 0, 0, 0));
        cyc(0, 0, 1, 8'h40, 0, E("br_run", 8'h81, 8'h00, 0, 1, 0));
        cyc(0, 0, 0, 8'h00, 0, E("tgt40", 8'h40, 8'hC9, 0, 0, 0));
        cyc(0, 1, 1, 8'h10, 0, E("br_sec", 8'h41, 8'h00, 1, 1, 0));
        cyc(0, 0, 0, 8'h00, 0, E("tgt10", 8'h10, 8'hC4, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 1, E("irq_sec", 8'h11, 8'h7E, 1, 0, 0));
        cyc(0, 0, 0, 8'h00, 1, E("irq_def", 8'h12, 8'h00, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 0, ER(E("int2", 8'h01, 8'h00, 0, 0, 1), 8'h12));
        cyc(0, 0, 1, 8'hFF, 0, E("br_ff", 8'h80, 8'h00, 0, 1, 0));
        cyc(0, 0, 0, 8'h00, 0, E("pc_ff", 8'hFF, 8'h33, 0, 0, 0));
        cyc(0, 0, 1, 8'hFF, 0, E("wrap", 8'h00, 8'h00, 0, 1, 0));
        mem[8'hFF] = 8'hC7;
        cyc(0, 0, 0, 8'h00, 0, E("tb_ff", 8'hFF, 8'hC7, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 0, E("tb_wrap", 8'h00, 8'h10, 1, 0, 0));
        cyc(0, 0, 0, 8'h00, 1, E("irq_01", 8'h01, 8'h00, 0, 0, 0));

        // reset asserted in the middle of the INT cycle
        irq = 1'b0;
        q.push_back(ER(E("int3", 8'h01, 8'h00, 0, 0, 1), 8'h01));
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async.addr", imem_addr, 8'h00);
        chk("async.ack", {7'd0, int_ack}, 8'h00);
        chk("async.ret", ret_pc, 8'h00);
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 8'h00, 0, ER(E("r_hold", 8'h00, 8'h00, 0, 0, 0), 8'h00));
        cyc(0, 0, 0, 8'h00, 0, E("r_vec", 8'h00, 8'h00, 0, 0, 0));
        cyc(0, 0, 0, 8'h00, 0, E("r_run", 8'h10, 8'hC4, 0, 0, 0));

        waits = 0;
        while (q.size() > 0 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        #1;
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
